// File: rtl/aes_sbox_sched.sv
// Time-shares NUM_SBOX external AES S-box lanes between the round datapath (128-bit SubBytes)
// and the key schedule (32-bit SubWord); NUM_SBOX bytes are substituted per RUN cycle.
//
//   state | meaning
//   IDLE  | waiting for a request; arbitration happens here only
//   RUN   | substituting NUM_SBOX bytes of the work register per cycle
//   ACK   | one-cycle ack pulse; requests ignored
module aes_sbox_sched #(
    parameter int NUM_SBOX = 4,
    parameter bit KEY_PRIO = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  st_req,
    input  logic [127:0]          st_in,
    output logic                  st_ack,
    output logic [127:0]          st_out,
    input  logic                  ks_req,
    input  logic [31:0]           ks_in,
    output logic                  ks_ack,
    output logic [31:0]           ks_out,
    output logic [8*NUM_SBOX-1:0] sb_addr,
    input  logic [8*NUM_SBOX-1:0] sb_data,
    output logic                  busy
);

    localparam int ST_LEN   = 16 / NUM_SBOX;
    localparam int KS_LEN   = (NUM_SBOX >= 4) ? 1 : 4 / NUM_SBOX;
    localparam int KS_LANES = (NUM_SBOX > 4) ? 4 : NUM_SBOX;

    if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 || NUM_SBOX == 8 || NUM_SBOX == 16))
    begin : g_bad_num_sbox
        $error("aes_sbox_sched: NUM_SBOX must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, RUN, ACK} state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [127:0]   work_q, work_d;
    logic [127:0]   st_out_q, st_out_d;
    logic [31:0]    ks_out_q, ks_out_d;
    logic           job_key_q, job_key_d;
    logic           last_key_q, last_key_d;
    logic           st_ack_q, st_ack_d;
    logic           ks_ack_q, ks_ack_d;

    logic           take_key;
    logic           last_cyc;
    logic [3:0]     idx;
    logic           lane_used;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        st_out_d   = st_out_q;
        ks_out_d   = ks_out_q;
        job_key_d  = job_key_q;
        last_key_d = last_key_q;
        st_ack_d   = 1'b0;
        ks_ack_d   = 1'b0;
        sb_addr    = '0;
        idx        = '0;
        lane_used  = 1'b0;
        // with KEY_PRIO=0 a tie goes to whoever was not granted last
        take_key   = ks_req && (!st_req || KEY_PRIO || !last_key_q);
        last_cyc   = job_key_q ? (cnt_q == 4'(KS_LEN - 1)) : (cnt_q == 4'(ST_LEN - 1));

        case (state_q)
            IDLE: begin
                if (st_req || ks_req) begin
                    state_d    = RUN;
                    cnt_d      = '0;
                    job_key_d  = take_key;
                    last_key_d = take_key;
                    work_d     = take_key ? {96'b0, ks_in} : st_in;
                end
            end
            RUN: begin
                for (int k = 0; k < NUM_SBOX; k++) begin
                    idx       = 4'(int'(cnt_q) * NUM_SBOX + k);
                    lane_used = !job_key_q || (k < KS_LANES);
                    if (lane_used) begin
                        sb_addr[8*k +: 8]  = work_q[8*idx +: 8];
                        work_d[8*idx +: 8] = sb_data[8*k +: 8];
                    end
                end
                cnt_d = cnt_q + 4'd1;
                if (last_cyc) begin
                    state_d = ACK;
                    if (job_key_q) begin
                        ks_out_d = work_d[31:0];
                        ks_ack_d = 1'b1;
                    end else begin
                        st_out_d = work_d;
                        st_ack_d = 1'b1;
                    end
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            work_q     <= '0;
            st_out_q   <= '0;
            ks_out_q   <= '0;
            job_key_q  <= 1'b0;
            last_key_q <= 1'b1;
            st_ack_q   <= 1'b0;
            ks_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            st_out_q   <= st_out_d;
            ks_out_q   <= ks_out_d;
            job_key_q  <= job_key_d;
            last_key_q <= last_key_d;
            st_ack_q   <= st_ack_d;
            ks_ack_q   <= ks_ack_d;
        end
    end

    assign st_ack = st_ack_q;
    assign ks_ack = ks_ack_q;
    assign st_out = st_out_q;
    assign ks_out = ks_out_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Bench for aes_sbox_sched: six instances (lane counts and tie policies) each fed by a
// FIPS-197 S-box table; directed vectors plus a per-lane-count random sweep.
module tb_aes_sbox_sched;

    localparam int NI = 6;
    localparam int NS_T [NI] = '{4, 4, 1, 2, 8, 16};
    localparam bit KP_T [NI] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst, st_req, ks_req, st_ack, ks_ack, busy;
    logic [127:0]  st_in [NI];
    logic [127:0]  st_out [NI];
    logic [127:0]  addr_w [NI];
    logic [31:0]   ks_in [NI];
    logic [31:0]   ks_out [NI];

    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [7:0] sb(input logic [7:0] a);
        return SBOX[a];
    endfunction

    function automatic logic [127:0] sub_model(input logic [127:0] x, input int nb);
        logic [127:0] r;
        r = '0;
        for (int b = 0; b < nb; b++) r[8*b +: 8] = sb(x[8*b +: 8]);
        return r;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int NS = NS_T[g];
        logic [8*NS-1:0] a;
        logic [8*NS-1:0] d;
        always_comb begin
            d = '0;
            for (int k = 0; k < NS; k++) d[8*k +: 8] = sb(a[8*k +: 8]);
        end
        assign addr_w[g] = 128'(a);
        aes_sbox_sched #(.NUM_SBOX(NS), .KEY_PRIO(KP_T[g])) u_dut (
            .clk(clk), .rst(rst[g]),
            .st_req(st_req[g]), .st_in(st_in[g]), .st_ack(st_ack[g]), .st_out(st_out[g]),
            .ks_req(ks_req[g]), .ks_in(ks_in[g]), .ks_ack(ks_ack[g]), .ks_out(ks_out[g]),
            .sb_addr(a), .sb_data(d), .busy(busy[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic job(input int i, input bit key, input logic [127:0] d, input bit scramble,
                       output logic [127:0] res, output int lat, output int busy_n);
        bit got;
        bit kind;
        logic [127:0] m;
        m = (NS_T[i] == 16) ? '1 : ((128'd1 << (8 * NS_T[i])) - 128'd1);
        @(negedge clk);
        if (key) begin ks_req[i] = 1'b1; ks_in[i] = d[31:0]; end
        else     begin st_req[i] = 1'b1; st_in[i] = d; end
        got = 1'b0; kind = 1'b0; lat = 0; busy_n = 0;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(negedge clk);
            if (busy[i]) busy_n++;
            if (n == 1) check($sformatf("addr_c0_i%0d", i), addr_w[i], d & m);
            if (scramble) st_in[i] = {$urandom, $urandom, $urandom, $urandom};
            if (st_ack[i] || ks_ack[i]) begin
                got = 1'b1; kind = ks_ack[i]; lat = n - 1;
                st_req[i] = 1'b0; ks_req[i] = 1'b0;
            end
        end
        check($sformatf("ack_seen_i%0d", i), 128'(got), 128'd1);
        check($sformatf("ack_kind_i%0d", i), 128'(kind), 128'(key));
        res = key ? 128'(ks_out[i]) : st_out[i];
    endtask

    task automatic tie(input int i, input bit exp_key_first, input logic [127:0] sd,
                       input logic [31:0] kd, input logic [127:0] s_exp, input logic [31:0] k_exp);
        bit got_s, got_k, first_key, seen_first, dual;
        got_s = 1'b0; got_k = 1'b0; first_key = 1'b0; seen_first = 1'b0; dual = 1'b0;
        @(negedge clk);
        st_req[i] = 1'b1; ks_req[i] = 1'b1; st_in[i] = sd; ks_in[i] = kd;
        for (int n = 0; n < 60 && !(got_s && got_k); n++) begin
            @(negedge clk);
            if (st_ack[i] && ks_ack[i]) dual = 1'b1;
            if ((st_ack[i] || ks_ack[i]) && !seen_first) begin
                seen_first = 1'b1; first_key = ks_ack[i];
            end
            if (st_ack[i]) begin got_s = 1'b1; st_req[i] = 1'b0; end
            if (ks_ack[i]) begin got_k = 1'b1; ks_req[i] = 1'b0; end
        end
        check($sformatf("tie_both_done_i%0d", i), 128'(got_s && got_k), 128'd1);
        check($sformatf("tie_order_i%0d", i), 128'(first_key), 128'(exp_key_first));
        check($sformatf("tie_dual_ack_i%0d", i), 128'(dual), 128'd0);
        check($sformatf("tie_st_out_i%0d", i), st_out[i], s_exp);
        check($sformatf("tie_ks_out_i%0d", i), 128'(ks_out[i]), 128'(k_exp));
    endtask

    initial begin
        logic [127:0] res, d;
        int lat, bn, exp_lat;
        bit acked;

        rst = '1; st_req = '0; ks_req = '0;
        for (int i = 0; i < NI; i++) begin st_in[i] = '0; ks_in[i] = '0; end
        repeat (3) @(negedge clk);
        check("rst_st_out", st_out[0], 128'd0);
        check("rst_ks_out", 128'(ks_out[0]), 128'd0);
        check("rst_busy", 128'(busy[0]), 128'd0);
        check("rst_acks", 128'({st_ack[0], ks_ack[0]}), 128'd0);
        check("rst_sb_addr", addr_w[0], 128'd0);
        rst = '0;

        job(0, 1'b0, 128'd0, 1'b0, res, lat, bn);
        check("st_zero_out", res, {16{8'h63}});
        check("st_zero_lat", 128'(lat), 128'd4);
        check("st_zero_busy", 128'(bn), 128'd5);

        job(0, 1'b1, 128'h0100FF53, 1'b0, res, lat, bn);
        check("ks_out", res, 128'h7C6316ED);
        check("ks_lat", 128'(lat), 128'd1);
        check("ks_st_unchanged", st_out[0], {16{8'h63}});

        tie(0, 1'b1, {16{8'h01}}, 32'h0, {16{8'h7c}}, 32'h63636363);
        tie(1, 1'b0, {16{8'hFF}}, 32'h53535353, {16{8'h16}}, 32'hEDEDEDED);

        job(0, 1'b0, {16{8'h53}}, 1'b1, res, lat, bn);
        check("st_sampled_at_accept", res, {16{8'hED}});

        @(negedge clk);
        st_req[0] = 1'b1; st_in[0] = {16{8'hAA}};
        @(negedge clk);
        @(negedge clk);
        rst[0] = 1'b1; st_req[0] = 1'b0;
        @(negedge clk);
        check("abort_busy", 128'(busy[0]), 128'd0);
        check("abort_st_out", st_out[0], 128'd0);
        check("abort_ks_out", 128'(ks_out[0]), 128'd0);
        check("abort_st_ack", 128'(st_ack[0]), 128'd0);
        rst[0] = 1'b0;
        acked = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (st_ack[0]) acked = 1'b1;
        end
        check("abort_no_ack", 128'(acked), 128'd0);
        job(0, 1'b0, {16{8'hAA}}, 1'b0, res, lat, bn);
        check("rereq_out", res, {16{8'hAC}});
        check("rereq_lat", 128'(lat), 128'd4);

        for (int i = 0; i < NI; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            job(i, 1'b0, d, 1'b0, res, lat, bn);
            check($sformatf("sweep_st_out_i%0d", i), res, sub_model(d, 16));
            check($sformatf("sweep_st_lat_i%0d", i), 128'(lat), 128'(16 / NS_T[i]));
            check($sformatf("sweep_st_busy_i%0d", i), 128'(bn), 128'(16 / NS_T[i] + 1));
            d = 128'($urandom);
            exp_lat = (NS_T[i] >= 4) ? 1 : 4 / NS_T[i];
            job(i, 1'b1, d, 1'b0, res, lat, bn);
            check($sformatf("sweep_ks_out_i%0d", i), res, sub_model(d, 4));
            check($sformatf("sweep_ks_lat_i%0d", i), 128'(lat), 128'(exp_lat));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
